// File: rtl/warp_scheduler.sv
// Round-robin warp issue scheduler: grants one eligible warp per cycle to the operand collector.
// Optional performance counters are enabled by defining WARP_SCHEDULER_PERF_CNT_EN.
module warp_scheduler #(
    parameter int NUM_WARPS    = 8,
    parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_WARPS-1:0]      valid_IB_WS,
    input  logic [NUM_WARPS-1:0]      dependent_Scb_WS,
    input  logic [NUM_WARPS-1:0]      full_Scb_WS,
    input  logic [2*NUM_WARPS-1:0]    ScbID_flattened_Scb_WS,
    input  logic                      stall_OC_WS,
    output logic [NUM_WARPS-1:0]      grt_WS_IB,
    output logic                      issue_valid_WS_OC,
    output logic [LOGNUM_WARPS-1:0]   issue_warpID_WS_OC,
    output logic [1:0]                issue_ScbID_WS_OC
`ifdef WARP_SCHEDULER_PERF_CNT_EN
    ,
    output logic [31:0]               issue_cnt_WS,
    output logic [31:0]               stall_cnt_WS
`endif
);

    localparam logic [LOGNUM_WARPS:0]   NUM_W_EXT = (LOGNUM_WARPS+1)'(NUM_WARPS);
    localparam logic [LOGNUM_WARPS-1:0] LAST_W    = LOGNUM_WARPS'(NUM_WARPS - 1);

    logic [LOGNUM_WARPS-1:0] rr_ptr_r;
    logic [NUM_WARPS-1:0]    blocked_r;
    logic [NUM_WARPS-1:0]    eligible_s;
    logic [LOGNUM_WARPS:0]   cand_s;
    logic                    hit_s;
    logic                    found_s;
    logic [LOGNUM_WARPS-1:0] gnt_idx_s;
    logic                    grant_s;
    logic [NUM_WARPS-1:0]    grt_s;
    logic [1:0]              gnt_scb_s;
    logic [LOGNUM_WARPS-1:0] rr_next_s;

    // Eligibility mask and wrap-around search for the first eligible warp at or after rr_ptr.
    always_comb begin
        eligible_s = valid_IB_WS & ~dependent_Scb_WS & ~full_Scb_WS & ~blocked_r;
        found_s    = 1'b0;
        hit_s      = 1'b0;
        gnt_idx_s  = LOGNUM_WARPS'(0);
        cand_s     = (LOGNUM_WARPS+1)'(0);
        for (int k = 0; k < NUM_WARPS; k++) begin
            cand_s    = {1'b0, rr_ptr_r} + (LOGNUM_WARPS+1)'(k);
            cand_s    = (cand_s >= NUM_W_EXT) ? (cand_s - NUM_W_EXT) : cand_s;
            hit_s     = ~found_s & eligible_s[cand_s[LOGNUM_WARPS-1:0]];
            gnt_idx_s = hit_s ? cand_s[LOGNUM_WARPS-1:0] : gnt_idx_s;
            found_s   = found_s | hit_s;
        end
    end

    // One-hot grant; suppressed by stall and while reset is asserted.
    always_comb begin
        grant_s = found_s & ~stall_OC_WS & rst;
        grt_s   = {NUM_WARPS{1'b0}};
        if (grant_s) begin
            grt_s[gnt_idx_s] = 1'b1;
        end else begin
            grt_s = {NUM_WARPS{1'b0}};
        end
    end

    // Only the granted warp's ScbID slice is selected, so other slices never reach the outputs.
    always_comb begin
        gnt_scb_s = ScbID_flattened_Scb_WS[{gnt_idx_s, 1'b0} +: 2];
        rr_next_s = (gnt_idx_s == LAST_W) ? LOGNUM_WARPS'(0) : (gnt_idx_s + LOGNUM_WARPS'(1));
    end

    assign grt_WS_IB = grt_s;

    // Round-robin pointer and one-cycle block of the warp just granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r  <= LOGNUM_WARPS'(0);
            blocked_r <= {NUM_WARPS{1'b0}};
        end else begin
            blocked_r <= grt_s;
            if (grant_s) begin
                rr_ptr_r <= rr_next_s;
            end
        end
    end

    // Issue registers: frozen while the operand collector stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid_WS_OC  <= 1'b0;
            issue_warpID_WS_OC <= LOGNUM_WARPS'(0);
            issue_ScbID_WS_OC  <= 2'd0;
        end else if (stall_OC_WS) begin
            issue_valid_WS_OC  <= issue_valid_WS_OC;
        end else if (grant_s) begin
            issue_valid_WS_OC  <= 1'b1;
            issue_warpID_WS_OC <= gnt_idx_s;
            issue_ScbID_WS_OC  <= gnt_scb_s;
        end else begin
            issue_valid_WS_OC  <= 1'b0;
        end
    end

`ifdef WARP_SCHEDULER_PERF_CNT_EN
    // Grant count and count of cycles with pending instructions but no grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_cnt_WS <= 32'd0;
            stall_cnt_WS <= 32'd0;
        end else begin
            if (grant_s) begin
                issue_cnt_WS <= issue_cnt_WS + 32'd1;
            end
            if (!grant_s && (|valid_IB_WS)) begin
                stall_cnt_WS <= stall_cnt_WS + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, number of warps arbitrated.
REQ-002 SHALL have parameter LOGNUM_WARPS, default $clog2(NUM_WARPS), warp ID width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port valid_IB_WS  input  NUM_WARPS  per-warp head instruction ready in IBuffer.
REQ-006 SHALL have port dependent_Scb_WS  input  NUM_WARPS  per-warp RAW/WAW hazard from scoreboard.
REQ-007 SHALL have port full_Scb_WS  input  NUM_WARPS  per-warp scoreboard full.
REQ-008 SHALL have port ScbID_flattened_Scb_WS  input  2*NUM_WARPS  per-warp next free ScbID, warp i at [2i+1:2i].
REQ-009 SHALL have port stall_OC_WS  input  1  operand collector cannot accept.
REQ-010 SHALL have port grt_WS_IB  output  NUM_WARPS  one-hot issue grant, drives IBuffer pop and scoreboard RP_grt.
REQ-011 SHALL have port issue_valid_WS_OC  output  1  registered issue valid to operand collector.
REQ-012 SHALL have port issue_warpID_WS_OC  output  LOGNUM_WARPS  registered issued warp ID.
REQ-013 SHALL have port issue_ScbID_WS_OC  output  2  registered ScbID of issued instruction.

Function
REQ-014 SHALL compute eligible[i] = valid_IB_WS[i] & ~dependent_Scb_WS[i] & ~full_Scb_WS[i] & ~blocked[i].
REQ-015 SHALL assert blocked[i] for exactly the cycle after warp i is granted (scoreboard entry not yet visible).
REQ-016 SHALL combinationally grant the first eligible warp at or after rr_ptr, searching upward, wrapping NUM_WARPS-1 to 0.
REQ-017 SHALL drive grt_WS_IB all-zero when stall_OC_WS=1 or no warp is eligible.
REQ-018 SHALL keep grt_WS_IB one-hot or zero in every cycle.
REQ-019 SHALL on a grant to warp w update rr_ptr to (w+1) mod NUM_WARPS at the next edge; otherwise hold rr_ptr.
REQ-020 SHALL on a grant to w register issue_valid_WS_OC=1, issue_warpID_WS_OC=w, issue_ScbID_WS_OC=ScbID of warp w, one-cycle latency.
REQ-021 SHALL when stall_OC_WS=1 hold all three issue_*_WS_OC registers unchanged.
REQ-022 SHALL when stall_OC_WS=0 and no grant, clear issue_valid_WS_OC to 0 and hold warpID/ScbID.
REQ-023 SHALL ignore ScbID of non-granted warps; X on those bits SHALL not propagate.
REQ-024 SHALL not clear blocked[i] early when stall_OC_WS rises in the following cycle; blocked lasts one cycle regardless.

Reset
REQ-025 SHALL on rst=0 asynchronously set rr_ptr=0, blocked=0, issue_valid_WS_OC=0, issue_warpID_WS_OC=0, issue_ScbID_WS_OC=0.
REQ-026 SHALL drive grt_WS_IB=0 while rst=0, including reset asserted mid-operation.
REQ-027 SHALL resume arbitration from warp 0 on the first edge after rst deasserts.

Configuration
REQ-028 SHALL, when macro WARP_SCHEDULER_PERF_CNT_EN is defined, add outputs issue_cnt_WS (32 bits, increments per grant) and stall_cnt_WS (32 bits, increments per cycle with any valid_IB_WS set but no grant), both wrapping at 2^32 and reset to 0.
REQ-029 SHALL, without WARP_SCHEDULER_PERF_CNT_EN, omit those ports and counters entirely, other behaviour identical.

Verification
REQ-030 SHALL verify round-robin: all 8 warps eligible for 16 cycles, stall=0 -> grants 0,1,...,7,0,...,7, but warp just granted never twice consecutively.
REQ-031 SHALL verify hazard masking: valid=8'hFF, dependent=8'h0F, full=8'h30, rr_ptr=0 -> first grant warp 6, then warp 7.
REQ-032 SHALL verify stall: grant warp 3 with ScbID 2, then stall_OC_WS=1 for 3 cycles -> grt=0, issue outputs hold {1,3,2} for all 3 cycles.
REQ-033 SHALL verify wrap and back-to-back block: only warp 7 eligible continuously -> grants in alternate cycles, rr_ptr wraps to 0.
REQ-034 SHALL verify async reset mid-issue: rst=0 between edges after a grant -> issue_valid_WS_OC=0 immediately, next grant after release starts search at warp 0.
REQ-035 SHALL verify counters with WARP_SCHEDULER_PERF_CNT_EN: 5 grants and 3 valid-but-blocked cycles -> issue_cnt_WS=5, stall_cnt_WS=3.
